dpram_pipe: RTL and testbench

Parameterised successor to the team's basic dual-port RAM: one write/read port A and one read-only port B, now with per-byte write enables, a configurable read pipeline with valid strobes, a selectable same-address collision policy on port B, and a hardware clear sequencer that zeroes the array one word per cycle without a reset-time loop. It is the standard buffer primitive for TX/RX sample and byte buffers in the OFDM datapaths.

---
 rtl/dpram_pkg.sv | 19 +
 rtl/dpram_pipe_if.sv | 38 +++
 rtl/dpram_pipe_stage.sv | 53 +++++
 rtl/dpram_pipe.sv | 184 ++++++++++++++++++
 tb/tb_dpram_pipe.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_pkg.sv
// dpram_pkg: definitions shared by the dpram_pipe block.
//   - Collision policy codes for the port B same-address-as-write case.
//   - Sequencer state encoding (idle / clear sweep).
//   - Derivation of the number of write-enable lanes per word.
package dpram_pkg;

    localparam int unsigned COLLISION_READ_FIRST  = 0;
    localparam int unsigned COLLISION_WRITE_FIRST = 1;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } dpram_state_e;

    function automatic int unsigned num_bytes(int unsigned data_width, int unsigned byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/dpram_pipe_if.sv
// dpram_pipe_if: bus bundle for dpram_pipe.
//   master (user side) drives clear, port A access/write and port B read requests;
//   slave (RAM side) returns busy, read words and their valid strobes.
interface dpram_pipe_if
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned BYTE_WIDTH    = 8
);
    localparam int unsigned NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);

    logic                     clear;
    logic                     busy;
    logic                     enable_a;
    logic [NUM_BYTES-1:0]     write_enable;
    logic [ADDRESS_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [DATA_WIDTH-1:0]    read_data_a;
    logic                     read_valid_a;
    logic                     enable_b;
    logic [ADDRESS_WIDTH-1:0] read_address;
    logic [DATA_WIDTH-1:0]    read_data;
    logic                     read_valid_b;

    modport master (
        output clear, enable_a, write_enable, write_address, write_data,
               enable_b, read_address,
        input  busy, read_data_a, read_valid_a, read_data, read_valid_b
    );

    modport slave (
        input  clear, enable_a, write_enable, write_address, write_data,
               enable_b, read_address,
        output busy, read_data_a, read_valid_a, read_data, read_valid_b
    );

endinterface

// File: rtl/dpram_pipe_stage.sv
// dpram_pipe_stage: data + valid delay line of Depth registers.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   data_i, valid_i   : word and strobe entering the line
//   data_o, valid_o   : word and strobe after Depth cycles
// A data register only loads when the strobe feeding it is high, so every
// tap (and the output) holds the last valid word between strobes.
// Depth = 0 is a pure pass-through.
module dpram_pipe_stage #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] data_i,
    input  logic             valid_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o
);

    if (Depth == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign data_o         = data_i;
        assign valid_o        = valid_i;
    end else begin : g_pipe
        logic [Depth-1:0] valid_q;
        logic [Width-1:0] data_q [Depth];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q <= '0;
                for (int k = 0; k < Depth; k++) begin
                    data_q[k] <= '0;
                end
            end else begin
                valid_q[0] <= valid_i;
                if (valid_i) begin
                    data_q[0] <= data_i;
                end
                for (int k = 1; k < Depth; k++) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
        end

        assign data_o  = data_q[Depth-1];
        assign valid_o = valid_q[Depth-1];
    end

endmodule

// File: rtl/dpram_pipe.sv
// dpram_pipe: dual-port RAM, port A read/write with byte enables, port B read-only.
//   clock  : sole clock, rising edge
//   reset  : asynchronous, active-high; aborts a clear sweep, zeroes outputs
//   bus    : dpram_pipe_if.slave (clear/busy, port A, port B, read strobes)
// Reads return data READ_LATENCY cycles after the enable. A clear pulse starts a
// sweep writing zero to one word per cycle; accesses are ignored while it runs.
module dpram_pipe
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned COLLISION_MODE = COLLISION_READ_FIRST
) (
    input logic         clock,
    input logic         reset,
    dpram_pipe_if.slave bus
);

    localparam int unsigned NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
    localparam int unsigned DEPTH     = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

    // ---------------- clear sequencer ----------------
    dpram_state_e             state_q;
    logic [ADDRESS_WIDTH-1:0] cnt_q;
    logic                     busy_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.clear) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StClear: begin
                    // clear is not looked at here, so re-pulses cannot stretch the sweep
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- access qualification ----------------
    logic en_a;
    logic en_b;
    logic collide;

    assign en_a = bus.enable_a && (state_q == StIdle);
    assign en_b = bus.enable_b && (state_q == StIdle);

    // Only a real byte write to the port B address counts as a collision.
    assign collide = en_a && en_b && (|bus.write_enable)
                  && (bus.write_address == bus.read_address)
                  && (COLLISION_MODE == COLLISION_WRITE_FIRST);

    // ---------------- array ----------------
    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
    logic [NUM_BYTES-1:0]     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;

    always_comb begin
        mem_we    = '0;
        mem_addr  = bus.write_address;
        mem_wdata = bus.write_data;
        if (state_q == StClear) begin
            mem_we    = '1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
        end else if (en_a) begin
            mem_we = bus.write_enable;
        end
    end

    // No reset on the array: contents survive reset and are cleared only by a sweep.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (mem_we[i]) begin
                mem_q[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                    mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // ---------------- read registers (first latency cycle) ----------------
    logic [DATA_WIDTH-1:0] rd_a_q;
    logic                  vld_a_q;
    logic [DATA_WIDTH-1:0] rd_b_q;
    logic                  vld_b_q;
    logic [DATA_WIDTH-1:0] col_wdata_q;
    logic [NUM_BYTES-1:0]  col_mask_q;

    // Nonblocking reads sample pre-write contents, giving read-first on both ports.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_a_q      <= '0;
            vld_a_q     <= 1'b0;
            rd_b_q      <= '0;
            vld_b_q     <= 1'b0;
            col_wdata_q <= '0;
            col_mask_q  <= '0;
        end else begin
            vld_a_q <= en_a;
            vld_b_q <= en_b;
            if (en_a) begin
                rd_a_q <= mem_q[bus.write_address];
            end
            if (en_b) begin
                rd_b_q      <= mem_q[bus.read_address];
                col_wdata_q <= bus.write_data;
                col_mask_q  <= collide ? bus.write_enable : '0;
            end
        end
    end

    // Write-first merge: substitute freshly written bytes into the old word.
    logic [DATA_WIDTH-1:0] rd_b_merged;

    always_comb begin
        rd_b_merged = rd_b_q;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (col_mask_q[i]) begin
                rd_b_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = col_wdata_q[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // ---------------- remaining latency ----------------
    logic [DATA_WIDTH-1:0] out_a;
    logic                  out_vld_a;
    logic [DATA_WIDTH-1:0] out_b;
    logic                  out_vld_b;

    dpram_pipe_stage #(
        .Width (DATA_WIDTH),
        .Depth (READ_LATENCY - 1)
    ) u_stage_a (
        .clk_i   (clock),
        .rst_i   (reset),
        .data_i  (rd_a_q),
        .valid_i (vld_a_q),
        .data_o  (out_a),
        .valid_o (out_vld_a)
    );

    dpram_pipe_stage #(
        .Width (DATA_WIDTH),
        .Depth (READ_LATENCY - 1)
    ) u_stage_b (
        .clk_i   (clock),
        .rst_i   (reset),
        .data_i  (rd_b_merged),
        .valid_i (vld_b_q),
        .data_o  (out_b),
        .valid_o (out_vld_b)
    );

    assign bus.busy         = busy_q;
    assign bus.read_data_a  = out_a;
    assign bus.read_valid_a = out_vld_a;
    assign bus.read_data    = out_b;
    assign bus.read_valid_b = out_vld_b;

endmodule

// File: tb/tb_dpram_pipe.sv
// tb_dpram_pipe: directed bench for dpram_pipe.
//   ux: ADDRESS_WIDTH=8, READ_LATENCY=1, READ_FIRST
//   uy: ADDRESS_WIDTH=8, READ_LATENCY=3, WRITE_FIRST   (same stimulus as ux)
//   uz: ADDRESS_WIDTH=4, READ_LATENCY=1, READ_FIRST    (own clear/reset, clear sweep tests)
module tb_dpram_pipe;
    import dpram_pkg::*;

    logic clk;
    logic rst;
    logic z_rst;

    logic        en_a;
    logic [3:0]  we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        en_b;
    logic [7:0]  raddr;
    logic        z_clear;

    int n_vec;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dpram_pipe_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .BYTE_WIDTH(8)) ifx ();
    dpram_pipe_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .BYTE_WIDTH(8)) ify ();
    dpram_pipe_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8)) ifz ();

    assign ifx.clear         = 1'b0;
    assign ifx.enable_a      = en_a;
    assign ifx.write_enable  = we;
    assign ifx.write_address = waddr;
    assign ifx.write_data    = wdata;
    assign ifx.enable_b      = en_b;
    assign ifx.read_address  = raddr;

    assign ify.clear         = 1'b0;
    assign ify.enable_a      = en_a;
    assign ify.write_enable  = we;
    assign ify.write_address = waddr;
    assign ify.write_data    = wdata;
    assign ify.enable_b      = en_b;
    assign ify.read_address  = raddr;

    assign ifz.clear         = z_clear;
    assign ifz.enable_a      = en_a;
    assign ifz.write_enable  = we;
    assign ifz.write_address = waddr[3:0];
    assign ifz.write_data    = wdata;
    assign ifz.enable_b      = en_b;
    assign ifz.read_address  = raddr[3:0];

    dpram_pipe #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(8), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .COLLISION_MODE(COLLISION_READ_FIRST)
    ) ux (.clock(clk), .reset(rst), .bus(ifx));

    dpram_pipe #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(8), .BYTE_WIDTH(8),
        .READ_LATENCY(3), .COLLISION_MODE(COLLISION_WRITE_FIRST)
    ) uy (.clock(clk), .reset(rst), .bus(ify));

    dpram_pipe #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .COLLISION_MODE(COLLISION_READ_FIRST)
    ) uz (.clock(clk), .reset(z_rst), .bus(ifz));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        en_a = 1'b0; we = 4'h0; en_b = 1'b0;
    endtask

    typedef struct {
        logic        en_a;
        logic [3:0]  we;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic        en_b;
        logic [7:0]  raddr;
        logic        chk_a;
        logic [31:0] exp_a;
        logic        chk_b;
        logic [31:0] exp_bx;  // READ_FIRST
        logic [31:0] exp_by;  // WRITE_FIRST
    } vec_t;

    vec_t vecs [11];

    task automatic fill_z();
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            en_a = 1'b1; we = 4'hF; waddr = 8'(k); wdata = 32'h5A00_0000 | 32'(k);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic read_z(input int a);
        @(posedge clk); #1;
        en_b = 1'b1; raddr = 8'(a);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    logic [31:0] seq_w [4];
    logic [31:0] prev_b;

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; z_rst = 1'b1; z_clear = 1'b0;
        idle_inputs(); waddr = '0; wdata = '0; raddr = '0;

        //               en_a we    waddr  wdata         en_b raddr  chk_a exp_a         chk_b exp_bx        exp_by
        vecs[0]  = '{1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b1, 4'h1, 8'h10, 32'h000000AA, 1'b0, 8'h00, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 4'h0, 8'h00, 32'h0,        1'b1, 8'h10, 1'b0, 32'h0,        1'b1, 32'hDEADBEAA, 32'hDEADBEAA};
        vecs[3]  = '{1'b1, 4'hF, 8'h05, 32'h11111111, 1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, 4'h3, 8'h05, 32'h22222222, 1'b1, 8'h05, 1'b1, 32'h11111111, 1'b1, 32'h11111111, 32'h11112222};
        vecs[5]  = '{1'b1, 4'h0, 8'h10, 32'h0,        1'b1, 8'h05, 1'b1, 32'hDEADBEAA, 1'b1, 32'h11112222, 32'h11112222};
        vecs[6]  = '{1'b1, 4'hF, 8'h20, 32'h01234567, 1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[7]  = '{1'b1, 4'hA, 8'h20, 32'hA5A5A5A5, 1'b1, 8'h10, 1'b1, 32'h01234567, 1'b1, 32'hDEADBEAA, 32'hDEADBEAA};
        vecs[8]  = '{1'b1, 4'h0, 8'h20, 32'hFFFFFFFF, 1'b1, 8'h20, 1'b1, 32'hA523A567, 1'b1, 32'hA523A567, 32'hA523A567};
        vecs[9]  = '{1'b1, 4'h8, 8'h20, 32'hFFFFFFFF, 1'b1, 8'h20, 1'b1, 32'hA523A567, 1'b1, 32'hA523A567, 32'hFF23A567};
        vecs[10] = '{1'b0, 4'hF, 8'h20, 32'hBAD0BAD0, 1'b1, 8'h20, 1'b0, 32'h0,        1'b1, 32'hFF23A567, 32'hFF23A567};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_x", 32'(ifx.busy), 32'h0);
        chk("rst_vld_a_x", 32'(ifx.read_valid_a), 32'h0);
        chk("rst_vld_b_y", 32'(ify.read_valid_b), 32'h0);
        chk("rst_data_a_y", ify.read_data_a, 32'h0);
        chk("rst_data_b_z", ifz.read_data, 32'h0);
        rst = 1'b0; z_rst = 1'b0;

        // ---- table vectors: x checked at latency 1, y at latency 3 ----
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            en_a = vecs[i].en_a; we = vecs[i].we; waddr = vecs[i].waddr;
            wdata = vecs[i].wdata; en_b = vecs[i].en_b; raddr = vecs[i].raddr;
            @(posedge clk); #1;
            idle_inputs();
            chk($sformatf("v%0d_x_vld_a", i), 32'(ifx.read_valid_a), 32'(vecs[i].en_a));
            chk($sformatf("v%0d_x_vld_b", i), 32'(ifx.read_valid_b), 32'(vecs[i].en_b));
            if (vecs[i].chk_a) chk($sformatf("v%0d_x_data_a", i), ifx.read_data_a, vecs[i].exp_a);
            if (vecs[i].chk_b) chk($sformatf("v%0d_x_data_b", i), ifx.read_data, vecs[i].exp_bx);
            @(posedge clk); #1;
            chk($sformatf("v%0d_x_vld_b_drop", i), 32'(ifx.read_valid_b), 32'h0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_y_vld_a", i), 32'(ify.read_valid_a), 32'(vecs[i].en_a));
            chk($sformatf("v%0d_y_vld_b", i), 32'(ify.read_valid_b), 32'(vecs[i].en_b));
            if (vecs[i].chk_a) chk($sformatf("v%0d_y_data_a", i), ify.read_data_a, vecs[i].exp_a);
            if (vecs[i].chk_b) chk($sformatf("v%0d_y_data_b", i), ify.read_data, vecs[i].exp_by);
        end

        // ---- back-to-back reads 0x10..0x13 ----
        seq_w[0] = 32'hDEADBEAA; seq_w[1] = 32'h00C0FFEE;
        seq_w[2] = 32'h12345678; seq_w[3] = 32'h87654321;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            en_a = 1'b1; we = 4'hF; waddr = 8'(8'h10 + k); wdata = seq_w[k];
        end
        @(posedge clk); #1;
        idle_inputs();
        prev_b = 32'hFF23A567;
        for (int t = 0; t < 9; t++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_t%0d_x_vld", t), 32'(ifx.read_valid_b),
                32'((t >= 1) && (t <= 4)));
            chk($sformatf("b2b_t%0d_x_data", t), ifx.read_data,
                (t < 1) ? prev_b : seq_w[(t - 1 > 3) ? 3 : t - 1]);
            chk($sformatf("b2b_t%0d_y_vld", t), 32'(ify.read_valid_b),
                32'((t >= 3) && (t <= 6)));
            chk($sformatf("b2b_t%0d_y_data", t), ify.read_data,
                (t < 3) ? prev_b : seq_w[(t - 3 > 3) ? 3 : t - 3]);
            if (t < 4) begin
                en_b = 1'b1; raddr = 8'(8'h10 + t);
            end else begin
                en_b = 1'b0;
            end
        end

        // ---- clear sweep on uz, re-pulse mid-sweep, enables held on ----
        fill_z();
        read_z(3);
        chk("z_pre_clear_data", ifz.read_data, 32'h5A000003);
        @(posedge clk); #1;
        z_clear = 1'b1;
        @(posedge clk); #1;
        z_clear = 1'b0;
        en_a = 1'b1; we = 4'h0; waddr = 8'h03; en_b = 1'b1; raddr = 8'h03;
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("clr_c%0d_busy", c), 32'(ifz.busy), 32'h1);
            chk($sformatf("clr_c%0d_vld", c), 32'({ifz.read_valid_a, ifz.read_valid_b}), 32'h0);
            chk($sformatf("clr_c%0d_hold", c), ifz.read_data, 32'h5A000003);
            z_clear = (c == 5);
            @(posedge clk); #1;
        end
        chk("clr_end_busy", 32'(ifz.busy), 32'h0);
        chk("clr_end_vld", 32'(ifz.read_valid_b), 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        chk("clr_fall_vld_b", 32'(ifz.read_valid_b), 32'h1);
        chk("clr_fall_data_b", ifz.read_data, 32'h0);
        chk("clr_fall_vld_a", 32'(ifz.read_valid_a), 32'h1);
        for (int a = 0; a < 16; a++) begin
            read_z(a);
            chk($sformatf("clr_rd%0d", a), ifz.read_data, 32'h0);
        end

        // ---- reset during sweep cycle 7 ----
        fill_z();
        read_z(9);
        @(posedge clk); #1;
        z_clear = 1'b1;
        @(posedge clk); #1;
        z_clear = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_busy_before", 32'(ifz.busy), 32'h1);
        z_rst = 1'b1;
        #1;
        chk("abort_busy", 32'(ifz.busy), 32'h0);
        chk("abort_data_b", ifz.read_data, 32'h0);
        chk("abort_vld", 32'({ifz.read_valid_a, ifz.read_valid_b}), 32'h0);
        #1;
        z_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy_stays", 32'(ifz.busy), 32'h0);
        for (int a = 0; a < 16; a++) begin
            read_z(a);
            chk($sformatf("abort_rd%0d", a), ifz.read_data,
                (a < 7) ? 32'h0 : (32'h5A00_0000 | 32'(a)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
